array_if_arb: RTL and testbench
===============================

// Module: array_if_arb
// PURPOSE
//  Single owner arbiter and mux for the shared DRAM array interface. Requesters: the refresh, read and write controllers.
//  Refresh has fixed top priority. Read and write alternate round-robin. A grant is held until that requester's done pulse.
//  After each ownership, the bus is idle for a programmable gap, then arbitration runs again.
//  Sits between the rd/wr/refresh controllers and the array pads. Array outputs are registered.
// PARAMETERS
//  AXI_ADDR_WIDTH   20                               total array address width
//  AXI_DATA_WIDTH   64                               array data width
//  AXI_RADDR_WIDTH  14                               row address width
//  AXI_CADDR_WIDTH  AXI_ADDR_WIDTH-AXI_RADDR_WIDTH   column address width
// PORTS
//  clk              in   1    clock
//  rst_n            in   1    asynchronous reset, active-low
//  mc_arb_gap_cfg   in   4    number of idle cycles between ownerships (0 = no gap state)
//  rf_req/rd_req/wr_req     in  1 each   request, level; held until granted
//  rf_done/rd_done/wr_done  in  1 each   one-cycle pulse from the owner; releases the grant
//  rf_gnt/rd_gnt/wr_gnt     out 1 each   grant, level, one-hot or zero
//  *_banksel_n_{rf,rd,wr}   in  1        per-source bank select, active-low
//  *_raddr_{rf,rd,wr}       in  RADDR    per-source row address
//  *_cas_{rd,wr}            in  1        per-source column strobe (refresh has none)
//  *_caddr_{rd,wr}          in  CADDR    per-source column address
//  array_wdata_wr           in  DATA     write data from the write controller
//  array_banksel_n  out  1      muxed bank select to the array
//  array_raddr      out  RADDR  muxed row address to the array
//  array_cas        out  1      muxed column strobe to the array
//  array_caddr      out  CADDR  muxed column address to the array
//  array_wdata      out  DATA   write data to the array
//  array_wr         out  1      high while the write controller owns the bus (array direction)
//  arb_busy         out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset values
//   - FSM is IDLE; all gnt are 0; arb_busy is 0.
//   - array_banksel_n=1, array_cas=0, array_raddr=0, array_caddr=all ones, array_wdata=0, array_wr=0.
//   - last_rdwr pointer = WR, so the first rd-vs-wr contest is won by read.
//  States: IDLE, OWN_RF, OWN_RD, OWN_WR, GAP.
//   - gnt is decoded directly from the state register: rf_gnt = (cs==OWN_RF), and likewise for rd and wr.
//  IDLE
//   - rf_req -> OWN_RF.
//   - Otherwise, rd_req and wr_req both high -> the source that is not last_rdwr.
//   - Otherwise, the single requesting source. With no request, stay in IDLE.
//  OWN_x: stay until x_done=1.
//   - On x_done: go to GAP if mc_arb_gap_cfg!=0, else go to IDLE.
//   - On leaving OWN_RD/OWN_WR, update last_rdwr.
//   - A request dropping while owned is ignored; only done releases the grant.
//   - A done from a non-owner is ignored in all states.
//  GAP
//   - gap_cnt is loaded with mc_arb_gap_cfg-1 on exit from OWN_x, then decrements.
//   - At gap_cnt==0, go to IDLE.
//   - cfg is sampled at load only; changing it mid-gap has no effect.
//  Refresh priority
//   - Refresh never preempts an active owner.
//   - Refresh wins every IDLE decision in which rf_req=1, including simultaneous rf/rd/wr requests.
//  Datapath mux
//   - Registered, 1-cycle latency: array_* at cycle n+1 reflects the owner's inputs at cycle n.
//   - When there is no owner (IDLE/GAP), array_* are driven to the reset values.
//     This guarantees banksel_n=1 and cas=0 during GAP.
//   - array_wdata is muxed from array_wdata_wr only in OWN_WR, else 0. array_wr is registered from (cs==OWN_WR).
//  Grant timing
//   - The IDLE decision in cycle n gives gnt=1 in cycle n+1.
//   - x_done in cycle m gives gnt=0 in cycle m+1.
//   - Minimum turnaround from done to the next gnt is mc_arb_gap_cfg+2 cycles.
//  Reset mid-operation: everything asynchronously returns to the reset values and any grant is dropped immediately.
// TESTING
//  1. Reset, rd_req=1 only, gap=0: rd_gnt=1 one cycle later. Drive rd_raddr=0x1234, rd_cas=1: array_raddr=0x1234 and array_cas=1 one cycle later. rd_done -> rd_gnt=0 next cycle.
//  2. rf_req, rd_req, wr_req all rise in the same cycle in IDLE: order of grants is rf, rd, wr; each grant is released only by its own done.
//  3. rd_req and wr_req held continuously with gap=0: grants alternate rd, wr, rd, wr and neither source is granted twice in a row.
//  4. gap=3, wr_done pulse: array_banksel_n=1 and no gnt for exactly 3 GAP cycles, then IDLE, then the next gnt.
//  5. rf_req rises while OWN_RD: rd keeps the bus until rd_done; rf_gnt follows the gap. A stray wr_done during OWN_RD changes nothing.
//  6. Assert rst_n=0 during OWN_WR with array_wr=1: all gnt=0, array_wr=0, array_banksel_n=1 immediately; after release, the next contest goes to read first.

Source files
------------

// File: rtl/array_if_arb.sv
// Single-owner arbiter and registered mux for the shared DRAM array interface.
// Refresh has fixed priority, read/write alternate, and an idle gap follows every ownership.
module array_if_arb #(
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_RADDR_WIDTH = 14,
    parameter int AXI_CADDR_WIDTH = AXI_ADDR_WIDTH - AXI_RADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 mc_arb_gap_cfg,
    input  logic                       rf_req,
    input  logic                       rd_req,
    input  logic                       wr_req,
    input  logic                       rf_done,
    input  logic                       rd_done,
    input  logic                       wr_done,
    output logic                       rf_gnt,
    output logic                       rd_gnt,
    output logic                       wr_gnt,
    input  logic                       array_banksel_n_rf,
    input  logic                       array_banksel_n_rd,
    input  logic                       array_banksel_n_wr,
    input  logic [AXI_RADDR_WIDTH-1:0] array_raddr_rf,
    input  logic [AXI_RADDR_WIDTH-1:0] array_raddr_rd,
    input  logic [AXI_RADDR_WIDTH-1:0] array_raddr_wr,
    input  logic                       array_cas_rd,
    input  logic                       array_cas_wr,
    input  logic [AXI_CADDR_WIDTH-1:0] array_caddr_rd,
    input  logic [AXI_CADDR_WIDTH-1:0] array_caddr_wr,
    input  logic [AXI_DATA_WIDTH-1:0]  array_wdata_wr,
    output logic                       array_banksel_n,
    output logic [AXI_RADDR_WIDTH-1:0] array_raddr,
    output logic                       array_cas,
    output logic [AXI_CADDR_WIDTH-1:0] array_caddr,
    output logic [AXI_DATA_WIDTH-1:0]  array_wdata,
    output logic                       array_wr,
    output logic                       arb_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OWN_RF,
        S_OWN_RD,
        S_OWN_WR,
        S_GAP
    } state_e;

    typedef enum logic {
        LAST_RD,
        LAST_WR
    } last_e;

    state_e cs_q, cs_d;
    last_e  last_rdwr_q, last_rdwr_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;

    logic                       banksel_n_q, banksel_n_d;
    logic [AXI_RADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                       cas_q, cas_d;
    logic [AXI_CADDR_WIDTH-1:0] caddr_q, caddr_d;
    logic [AXI_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                       wr_q, wr_d;

    // Where an owner goes once its done arrives.
    state_e release_st;
    assign release_st = (mc_arb_gap_cfg != 4'd0) ? S_GAP : S_IDLE;

    // ------------------------------------------------------------------
    // Arbitration FSM: next state
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so no path can leave it unassigned and infer a latch.
    always_comb begin
        cs_d        = cs_q;
        last_rdwr_d = last_rdwr_q;
        gap_cnt_d   = gap_cnt_q;
        unique case (cs_q)
            S_IDLE: begin
                if (rf_req) begin
                    cs_d = S_OWN_RF;
                end else if (rd_req && wr_req) begin
                    cs_d = (last_rdwr_q == LAST_WR) ? S_OWN_RD : S_OWN_WR;
                end else if (rd_req) begin
                    cs_d = S_OWN_RD;
                end else if (wr_req) begin
                    cs_d = S_OWN_WR;
                end
            end
            S_OWN_RF: begin
                if (rf_done) begin
                    cs_d      = release_st;
                    gap_cnt_d = mc_arb_gap_cfg - 4'd1;
                end
            end
            S_OWN_RD: begin
                if (rd_done) begin
                    cs_d        = release_st;
                    gap_cnt_d   = mc_arb_gap_cfg - 4'd1;
                    last_rdwr_d = LAST_RD;
                end
            end
            S_OWN_WR: begin
                if (wr_done) begin
                    cs_d        = release_st;
                    gap_cnt_d   = mc_arb_gap_cfg - 4'd1;
                    last_rdwr_d = LAST_WR;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    cs_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: cs_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q        <= S_IDLE;
            last_rdwr_q <= LAST_WR;
            gap_cnt_q   <= 4'd0;
        end else begin
            cs_q        <= cs_d;
            last_rdwr_q <= last_rdwr_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign rf_gnt   = (cs_q == S_OWN_RF);
    assign rd_gnt   = (cs_q == S_OWN_RD);
    assign wr_gnt   = (cs_q == S_OWN_WR);
    assign arb_busy = (cs_q != S_IDLE);

    // ------------------------------------------------------------------
    // Array datapath: idle values unless someone owns the bus this cycle
    // ------------------------------------------------------------------
    always_comb begin
        banksel_n_d = 1'b1;
        raddr_d     = '0;
        cas_d       = 1'b0;
        caddr_d     = '1;
        wdata_d     = '0;
        wr_d        = (cs_q == S_OWN_WR);
        unique case (cs_q)
            S_OWN_RF: begin
                banksel_n_d = array_banksel_n_rf;
                raddr_d     = array_raddr_rf;
            end
            S_OWN_RD: begin
                banksel_n_d = array_banksel_n_rd;
                raddr_d     = array_raddr_rd;
                cas_d       = array_cas_rd;
                caddr_d     = array_caddr_rd;
            end
            S_OWN_WR: begin
                banksel_n_d = array_banksel_n_wr;
                raddr_d     = array_raddr_wr;
                cas_d       = array_cas_wr;
                caddr_d     = array_caddr_wr;
                wdata_d     = array_wdata_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            banksel_n_q <= 1'b1;
            raddr_q     <= '0;
            cas_q       <= 1'b0;
            caddr_q     <= '1;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
        end else begin
            banksel_n_q <= banksel_n_d;
            raddr_q     <= raddr_d;
            cas_q       <= cas_d;
            caddr_q     <= caddr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
        end
    end

    assign array_banksel_n = banksel_n_q;
    assign array_raddr     = raddr_q;
    assign array_cas       = cas_q;
    assign array_caddr     = caddr_q;
    assign array_wdata     = wdata_q;
    assign array_wr        = wr_q;

    // The grants come straight from the state register, so at most one can ever be high.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({rf_gnt, rd_gnt, wr_gnt}));

endmodule

// File: tb/tb_array_if_arb.sv
// Self-checking bench for array_if_arb: directed scenarios plus randomized traffic
// checked cycle by cycle against an ownership-level reference model.
module tb_array_if_arb;

    localparam int RW = 14;
    localparam int CW = 6;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    mc_arb_gap_cfg;
    logic          rf_req, rd_req, wr_req;
    logic          rf_done, rd_done, wr_done;
    logic          rf_gnt, rd_gnt, wr_gnt;
    logic          bs_rf, bs_rd, bs_wr;
    logic [RW-1:0] ra_rf, ra_rd, ra_wr;
    logic          cas_rd, cas_wr;
    logic [CW-1:0] ca_rd, ca_wr;
    logic [DW-1:0] wd_wr;
    logic          array_banksel_n;
    logic [RW-1:0] array_raddr;
    logic          array_cas;
    logic [CW-1:0] array_caddr;
    logic [DW-1:0] array_wdata;
    logic          array_wr;
    logic          arb_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    array_if_arb dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mc_arb_gap_cfg     (mc_arb_gap_cfg),
        .rf_req             (rf_req),
        .rd_req             (rd_req),
        .wr_req             (wr_req),
        .rf_done            (rf_done),
        .rd_done            (rd_done),
        .wr_done            (wr_done),
        .rf_gnt             (rf_gnt),
        .rd_gnt             (rd_gnt),
        .wr_gnt             (wr_gnt),
        .array_banksel_n_rf (bs_rf),
        .array_banksel_n_rd (bs_rd),
        .array_banksel_n_wr (bs_wr),
        .array_raddr_rf     (ra_rf),
        .array_raddr_rd     (ra_rd),
        .array_raddr_wr     (ra_wr),
        .array_cas_rd       (cas_rd),
        .array_cas_wr       (cas_wr),
        .array_caddr_rd     (ca_rd),
        .array_caddr_wr     (ca_wr),
        .array_wdata_wr     (wd_wr),
        .array_banksel_n    (array_banksel_n),
        .array_raddr        (array_raddr),
        .array_cas          (array_cas),
        .array_caddr        (array_caddr),
        .array_wdata        (array_wdata),
        .array_wr           (array_wr),
        .arb_busy           (arb_busy)
    );

    // Advance one clock and land 1 ns after the edge, where outputs are sampled and inputs changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rf_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        rf_done = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
        bs_rf = 1'b1; bs_rd = 1'b1; bs_wr = 1'b1;
        ra_rf = '0; ra_rd = '0; ra_wr = '0;
        cas_rd = 1'b0; cas_wr = 1'b0;
        ca_rd = '0; ca_wr = '0;
        wd_wr = '0;
    endtask

    task automatic apply_reset(input logic [3:0] gap);
        idle_inputs();
        mc_arb_gap_cfg = gap;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // which: 1 = refresh, 2 = read, 3 = write
    task automatic pulse_done(input int which);
        rf_done = (which == 1);
        rd_done = (which == 2);
        wr_done = (which == 3);
        tick();
        rf_done = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(4'd0);
        n_vec++;
        if ({rf_gnt, rd_gnt, wr_gnt, arb_busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_gnt_busy: got %b want 0000", {rf_gnt, rd_gnt, wr_gnt, arb_busy});
        end
        n_vec++;
        if ({array_banksel_n, array_cas, array_wr} !== 3'b100 || array_raddr !== '0
            || array_caddr !== '1 || array_wdata !== '0) begin
            n_err++;
            $display("FAIL reset_array: got bs=%b cas=%b wr=%b ra=%h ca=%h wd=%h want bs=1 cas=0 wr=0 ra=0 ca=3f wd=0",
                     array_banksel_n, array_cas, array_wr, array_raddr, array_caddr, array_wdata);
        end
    endtask

    task automatic test_single_rd();
        apply_reset(4'd0);
        rd_req = 1'b1;
        tick();
        n_vec++;
        if ({rf_gnt, rd_gnt, wr_gnt} !== 3'b010) begin
            n_err++;
            $display("FAIL single_rd_gnt: got %b want 010", {rf_gnt, rd_gnt, wr_gnt});
        end
        rd_req = 1'b0;
        ra_rd = 14'h1234; cas_rd = 1'b1; bs_rd = 1'b0; ca_rd = 6'h15;
        tick();
        n_vec++;
        if (array_raddr !== 14'h1234 || array_cas !== 1'b1 || array_banksel_n !== 1'b0
            || array_caddr !== 6'h15 || array_wr !== 1'b0) begin
            n_err++;
            $display("FAIL single_rd_mux: got ra=%h cas=%b bs=%b ca=%h wr=%b want ra=1234 cas=1 bs=0 ca=15 wr=0",
                     array_raddr, array_cas, array_banksel_n, array_caddr, array_wr);
        end
        pulse_done(2);
        n_vec++;
        if ({rf_gnt, rd_gnt, wr_gnt, arb_busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL single_rd_release: got %b want 0000", {rf_gnt, rd_gnt, wr_gnt, arb_busy});
        end
        tick();
        n_vec++;
        if (array_cas !== 1'b0 || array_banksel_n !== 1'b1 || array_raddr !== '0 || array_caddr !== '1) begin
            n_err++;
            $display("FAIL single_rd_idle_array: got cas=%b bs=%b ra=%h ca=%h want cas=0 bs=1 ra=0 ca=3f",
                     array_cas, array_banksel_n, array_raddr, array_caddr);
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_seq [3];
        exp_seq[0] = 3'b100; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001;
        apply_reset(4'd0);
        rf_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if ({rf_gnt, rd_gnt, wr_gnt} !== exp_seq[k]) begin
                n_err++;
                $display("FAIL priority_order_%0d: got %b want %b", k, {rf_gnt, rd_gnt, wr_gnt}, exp_seq[k]);
            end
            if (k == 0) rf_req = 1'b0;
            if (k == 1) rd_req = 1'b0;
            if (k == 2) wr_req = 1'b0;
            // A foreign done must not release the current owner.
            pulse_done((k == 0) ? 3 : 1);
            n_vec++;
            if ({rf_gnt, rd_gnt, wr_gnt} !== exp_seq[k]) begin
                n_err++;
                $display("FAIL priority_hold_%0d: got %b want %b", k, {rf_gnt, rd_gnt, wr_gnt}, exp_seq[k]);
            end
            pulse_done(k + 1);
        end
    endtask

    task automatic test_alternate();
        logic exp_rd;
        int   waited;
        apply_reset(4'd0);
        rd_req = 1'b1; wr_req = 1'b1;
        exp_rd = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            while (!rd_gnt && !wr_gnt && waited < 8) begin
                tick();
                waited++;
            end
            n_vec++;
            if ({rd_gnt, wr_gnt} !== (exp_rd ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL alternate_%0d: got rd=%b wr=%b want rd=%b wr=%b", k, rd_gnt, wr_gnt, exp_rd, !exp_rd);
            end
            repeat ($urandom_range(0, 2)) tick();
            if (rd_gnt) pulse_done(2);
            else if (wr_gnt) pulse_done(3);
            exp_rd = !exp_rd;
        end
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic test_gap();
        logic [DW-1:0] wd;
        wd = {$urandom, $urandom};
        apply_reset(4'd3);
        wr_req = 1'b1; bs_wr = 1'b0; wd_wr = wd;
        tick();
        n_vec++;
        if (wr_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL gap_wr_gnt: got %b want 1", wr_gnt);
        end
        wr_req = 1'b0; rd_req = 1'b1;
        tick();
        n_vec++;
        if (array_banksel_n !== 1'b0 || array_wr !== 1'b1 || array_wdata !== wd) begin
            n_err++;
            $display("FAIL gap_wr_mux: got bs=%b wr=%b wd=%h want bs=0 wr=1 wd=%h", array_banksel_n, array_wr, array_wdata, wd);
        end
        bs_wr = 1'b1;
        pulse_done(3);
        mc_arb_gap_cfg = 4'd9;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) tick();
            n_vec++;
            if ({rf_gnt, rd_gnt, wr_gnt} !== 3'b000 || arb_busy !== 1'b1 || array_banksel_n !== 1'b1) begin
                n_err++;
                $display("FAIL gap_cycle_%0d: got gnt=%b busy=%b bs=%b want gnt=000 busy=1 bs=1",
                         k, {rf_gnt, rd_gnt, wr_gnt}, arb_busy, array_banksel_n);
            end
        end
        tick();
        n_vec++;
        if ({rf_gnt, rd_gnt, wr_gnt} !== 3'b000 || arb_busy !== 1'b0 || array_cas !== 1'b0) begin
            n_err++;
            $display("FAIL gap_idle: got gnt=%b busy=%b cas=%b want gnt=000 busy=0 cas=0",
                     {rf_gnt, rd_gnt, wr_gnt}, arb_busy, array_cas);
        end
        tick();
        n_vec++;
        if ({rf_gnt, rd_gnt, wr_gnt} !== 3'b010) begin
            n_err++;
            $display("FAIL gap_next_gnt: got %b want 010", {rf_gnt, rd_gnt, wr_gnt});
        end
        rd_req = 1'b0;
        pulse_done(2);
    endtask

    task automatic test_rf_during_rd();
        int waited;
        apply_reset(4'd2);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0; rf_req = 1'b1;
        repeat (3) tick();
        pulse_done(3);
        n_vec++;
        if ({rf_gnt, rd_gnt, wr_gnt} !== 3'b010) begin
            n_err++;
            $display("FAIL rf_no_preempt: got %b want 010", {rf_gnt, rd_gnt, wr_gnt});
        end
        pulse_done(2);
        waited = 1;
        while (!rf_gnt && waited < 12) begin
            n_vec++;
            if ({rd_gnt, wr_gnt} !== 2'b00) begin
                n_err++;
                $display("FAIL rf_wait_gnt: got rd=%b wr=%b want 00", rd_gnt, wr_gnt);
            end
            tick();
            waited++;
        end
        n_vec++;
        if (rf_gnt !== 1'b1 || waited != 4) begin
            n_err++;
            $display("FAIL rf_turnaround: got gnt=%b after %0d cycles want gnt=1 after 4", rf_gnt, waited);
        end
        rf_req = 1'b0;
        pulse_done(1);
    endtask

    task automatic test_reset_mid();
        apply_reset(4'd0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        pulse_done(2);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        n_vec++;
        if (wr_gnt !== 1'b1 || array_wr !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: got gnt=%b array_wr=%b want 1 1", wr_gnt, array_wr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rf_gnt, rd_gnt, wr_gnt, arb_busy, array_wr, array_banksel_n} !== 6'b000001) begin
            n_err++;
            $display("FAIL rstmid_async: got gnt/busy/wr/bs=%b want 000001",
                     {rf_gnt, rd_gnt, wr_gnt, arb_busy, array_wr, array_banksel_n});
        end
        tick();
        rst_n = 1'b1;
        rd_req = 1'b1; wr_req = 1'b1;
        tick();
        n_vec++;
        if ({rf_gnt, rd_gnt, wr_gnt} !== 3'b010) begin
            n_err++;
            $display("FAIL rstmid_first_rd: got %b want 010", {rf_gnt, rd_gnt, wr_gnt});
        end
        rd_req = 1'b0; wr_req = 1'b0;
        pulse_done(2);
    endtask

    // Reference model: tracks who owns the bus, how many gap cycles remain and who last
    // held it as read/write; the array outputs follow whoever owned it during the previous cycle.
    task automatic test_random();
        int            owner;     // 0 none, 1 refresh, 2 read, 3 write
        int            gap_left;
        int            last;
        logic          e_bs, e_cas, e_wr;
        logic [RW-1:0] e_ra;
        logic [CW-1:0] e_ca;
        logic [DW-1:0] e_wd;
        apply_reset(4'd0);
        owner = 0; gap_left = 0; last = 3;
        repeat (2000) begin
            rf_req  = ($urandom_range(0, 3) == 0);
            rd_req  = $urandom_range(0, 1) == 1;
            wr_req  = $urandom_range(0, 1) == 1;
            rf_done = ($urandom_range(0, 2) == 0);
            rd_done = ($urandom_range(0, 2) == 0);
            wr_done = ($urandom_range(0, 2) == 0);
            bs_rf = $urandom_range(0, 1) == 1; bs_rd = $urandom_range(0, 1) == 1; bs_wr = $urandom_range(0, 1) == 1;
            ra_rf = RW'($urandom); ra_rd = RW'($urandom); ra_wr = RW'($urandom);
            cas_rd = $urandom_range(0, 1) == 1; cas_wr = $urandom_range(0, 1) == 1;
            ca_rd = CW'($urandom); ca_wr = CW'($urandom);
            wd_wr = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) mc_arb_gap_cfg = 4'($urandom_range(0, 3));

            e_bs = 1'b1; e_ra = '0; e_cas = 1'b0; e_ca = '1; e_wd = '0; e_wr = (owner == 3);
            if (owner == 1) begin e_bs = bs_rf; e_ra = ra_rf; end
            if (owner == 2) begin e_bs = bs_rd; e_ra = ra_rd; e_cas = cas_rd; e_ca = ca_rd; end
            if (owner == 3) begin e_bs = bs_wr; e_ra = ra_wr; e_cas = cas_wr; e_ca = ca_wr; e_wd = wd_wr; end

            if (owner == 0) begin
                if (gap_left > 0) gap_left--;
                else if (rf_req) owner = 1;
                else if (rd_req && wr_req) owner = (last == 3) ? 2 : 3;
                else if (rd_req) owner = 2;
                else if (wr_req) owner = 3;
            end else if ((owner == 1 && rf_done) || (owner == 2 && rd_done) || (owner == 3 && wr_done)) begin
                if (owner != 1) last = owner;
                gap_left = int'(mc_arb_gap_cfg);
                owner = 0;
            end

            tick();
            n_vec++;
            if ({rf_gnt, rd_gnt, wr_gnt, arb_busy} !== {owner == 1, owner == 2, owner == 3, (owner != 0 || gap_left > 0)}) begin
                n_err++;
                $display("FAIL random_gnt: got gnt/busy=%b want owner=%0d gap_left=%0d",
                         {rf_gnt, rd_gnt, wr_gnt, arb_busy}, owner, gap_left);
            end
            n_vec++;
            if ({array_banksel_n, array_raddr, array_cas, array_caddr, array_wdata, array_wr}
                !== {e_bs, e_ra, e_cas, e_ca, e_wd, e_wr}) begin
                n_err++;
                $display("FAIL random_array: got bs=%b ra=%h cas=%b ca=%h wd=%h wr=%b want bs=%b ra=%h cas=%b ca=%h wd=%h wr=%b",
                         array_banksel_n, array_raddr, array_cas, array_caddr, array_wdata, array_wr,
                         e_bs, e_ra, e_cas, e_ca, e_wd, e_wr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_rd();
        test_priority();
        test_alternate();
        test_gap();
        test_rf_during_rd();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
